innerproduct_sched: RTL



---
 rtl/innerproduct_sched.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/innerproduct_sched.sv
// innerproduct_sched
//   Time-shares one multiply-accumulate unit across NCLASS weight sets.
//   A window of NFEAT-1 pixels is loaded into a local buffer, then theta
//   words are streamed from an external synchronous ROM (one per cycle,
//   back-to-back across all classes). Each class score is emitted as it
//   completes, followed by the argmax class and its score.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   x_valid/x_data      pixel input (unsigned XW bits)
//   x_ready             high while loading (LOAD state)
//   theta_rd/addr       ROM read strobe and address (class*NFEAT+feature)
//   theta_data          ROM data, valid the cycle after theta_rd
//   res_valid/class/value   per-class score pulse (values hold)
//   done_valid/class/value  argmax pulse at end of window (values hold)
//   busy                high outside LOAD
module innerproduct_sched #(
    parameter int NFEAT  = 81,
    parameter int NCLASS = 10,
    parameter int XW     = 7,
    parameter int TW     = 32,
    parameter int AW     = 10,
    parameter int CW     = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          x_valid,
    input  logic [XW-1:0] x_data,
    output logic          x_ready,
    output logic          theta_rd,
    output logic [AW-1:0] theta_addr,
    input  logic [TW-1:0] theta_data,
    output logic          res_valid,
    output logic [CW-1:0] res_class,
    output logic [31:0]   res_value,
    output logic          done_valid,
    output logic [CW-1:0] done_class,
    output logic [31:0]   done_value,
    output logic          busy
);

    localparam int KW     = $clog2(NFEAT);
    localparam int NTERMS = NCLASS * NFEAT;

    typedef enum logic [1:0] {
        S_LOAD,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state;
    logic [KW-1:0] count;
    logic [KW-1:0] feat;
    logic [CW-1:0] cls;
    // Issue-side feature/class delayed to line up with the returned ROM word
    logic          rd_d;
    logic [KW-1:0] feat_d;
    logic [CW-1:0] cls_d;
    logic [31:0]   acc;
    logic [31:0]   max_value;
    logic [CW-1:0] max_class;

    // Pixel store; index 0 is the bias slot and is never read
    logic [XW-1:0] buffer [1:NFEAT-1];

    logic          accept;
    logic [31:0]   theta_ext;
    logic [31:0]   pix_ext;
    logic [31:0]   term;
    logic [31:0]   next_acc;

    assign accept = x_valid && x_ready;

    always_comb begin
        theta_ext = 32'($signed(theta_data));
        pix_ext   = '0;
        if (feat_d != '0) begin
            pix_ext = 32'(buffer[feat_d]);
        end
        term = pix_ext * theta_ext;
        // Bias term restarts the accumulator, so no explicit clear between classes
        if (feat_d == '0) begin
            next_acc = theta_ext << 16;
        end else begin
            next_acc = acc + term;
        end
    end

    // Buffer is not reset: every entry is rewritten before it is read
    always_ff @(posedge clk) begin
        if (accept) begin
            buffer[KW'(count + 1'b1)] <= x_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_LOAD;
            x_ready    <= 1'b1;
            busy       <= 1'b0;
            count      <= '0;
            feat       <= '0;
            cls        <= '0;
            rd_d       <= 1'b0;
            feat_d     <= '0;
            cls_d      <= '0;
            acc        <= '0;
            max_value  <= '0;
            max_class  <= '0;
            theta_rd   <= 1'b0;
            theta_addr <= '0;
            res_valid  <= 1'b0;
            res_class  <= '0;
            res_value  <= '0;
            done_valid <= 1'b0;
            done_class <= '0;
            done_value <= '0;
        end else begin
            res_valid  <= 1'b0;
            done_valid <= 1'b0;
            rd_d       <= theta_rd;
            feat_d     <= feat;
            cls_d      <= cls;

            // Return path: one ROM word per cycle after its issue
            if (rd_d) begin
                acc <= next_acc;
                if (feat_d == KW'(NFEAT - 1)) begin
                    res_valid <= 1'b1;
                    res_class <= cls_d;
                    res_value <= next_acc;
                    // Strictly greater keeps the lowest index on ties
                    if (cls_d == '0 || $signed(next_acc) > $signed(max_value)) begin
                        max_value <= next_acc;
                        max_class <= cls_d;
                    end
                end
            end

            case (state)
                S_LOAD: begin
                    if (accept) begin
                        if (count == KW'(NFEAT - 2)) begin
                            count      <= '0;
                            state      <= S_COMPUTE;
                            x_ready    <= 1'b0;
                            busy       <= 1'b1;
                            theta_rd   <= 1'b1;
                            theta_addr <= '0;
                            feat       <= '0;
                            cls        <= '0;
                        end else begin
                            count <= KW'(count + 1'b1);
                        end
                    end
                end
                S_COMPUTE: begin
                    if (theta_addr == AW'(NTERMS - 1)) begin
                        theta_rd <= 1'b0;
                        state    <= S_DRAIN;
                    end else begin
                        theta_addr <= AW'(theta_addr + 1'b1);
                        if (feat == KW'(NFEAT - 1)) begin
                            feat <= '0;
                            cls  <= CW'(cls + 1'b1);
                        end else begin
                            feat <= KW'(feat + 1'b1);
                        end
                    end
                end
                S_DRAIN: begin
                    state <= S_DONE;
                end
                S_DONE: begin
                    done_valid <= 1'b1;
                    done_class <= max_class;
                    done_value <= max_value;
                    x_ready    <= 1'b1;
                    busy       <= 1'b0;
                    state      <= S_LOAD;
                end
                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

endmodule
